// File: rtl/seg_scan_if.sv
// Signal bundle between the interface controller and the 7-segment scan driver.
// The controller side drives row/cursor/protect and observes the display pins.
interface seg_scan_if;
    logic [15:0] currentRow;
    logic [3:0]  currentNum;
    logic        noWrite;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frameTick;

    modport master (
        output currentRow, currentNum, noWrite,
        input  seg, dp, an, frameTick
    );

    modport slave (
        input  currentRow, currentNum, noWrite,
        output seg, dp, an, frameTick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with cursor blink,
// write-protect decimal point and frame-aligned shadowing of the displayed row.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD     = 4,
    parameter int BLINK_DIV = 64
) (
    input logic       CLK,
    input logic       RST,
    seg_scan_if.slave bus
);

    logic [15:0] presc;
    logic [1:0]  idx;
    logic [15:0] blink_cnt;
    logic        blink_hidden;

    logic [15:0] row_sh;
    logic [3:0]  cur_sh;
    logic        nw_sh;

    logic        slot_end;
    logic        frame_end;
    logic [3:0]  nib;

    logic [3:0]  an_d;
    logic [6:0]  seg_d;
    logic        dp_d;

    logic [3:0]  an_p0;
    logic [6:0]  seg_p0;
    logic        dp_p0;
    logic        tick_p0;

    // Active-low {g,f,e,d,c,b,a}; zero is deliberately blank rather than a glyph.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1111111;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign slot_end  = (presc == 16'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx == 2'd3);
    assign nib       = row_sh[{idx, 2'b00} +: 4];

    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        // Anodes stay dark for the first GUARD cycles of a slot to hide segment settling.
        if (presc >= 16'(GUARD)) begin
            an_d  = ~(4'b0001 << idx);
            seg_d = (cur_sh[idx] && blink_hidden) ? 7'h7F : decode(nib);
            dp_d  = ~(cur_sh[idx] & nw_sh);
        end
    end

    // Stage 0: scan counters, frame shadows and registered display pins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc        <= '0;
            idx          <= '0;
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
            row_sh       <= '0;
            cur_sh       <= '0;
            nw_sh        <= 1'b0;
            an_p0        <= 4'hF;
            seg_p0       <= 7'h7F;
            dp_p0        <= 1'b1;
            tick_p0      <= 1'b0;
        end else begin
            presc <= slot_end ? 16'd0 : presc + 16'd1;
            if (slot_end)
                idx <= idx + 2'd1;
            if (frame_end) begin
                row_sh <= bus.currentRow;
                cur_sh <= bus.currentNum;
                nw_sh  <= bus.noWrite;
                if (blink_cnt == 16'(BLINK_DIV - 1)) begin
                    blink_cnt    <= '0;
                    blink_hidden <= ~blink_hidden;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
            an_p0   <= an_d;
            seg_p0  <= seg_d;
            dp_p0   <= dp_d;
            tick_p0 <= frame_end;
        end
    end

    assign bus.an        = an_p0;
    assign bus.seg       = seg_p0;
    assign bus.dp        = dp_p0;
    assign bus.frameTick = tick_p0;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, GUARD=2, BLINK_DIV=2.
// Cycle c counts rising edges since reset release; outputs in cycle c reflect scan state c-1.
module tb_seg_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   n_vec = 0;
    int   n_bad = 0;

    seg_scan_if bus ();

    seg_scan_driver #(
        .SCAN_DIV (8),
        .GUARD    (2),
        .BLINK_DIV(2)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int          c;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        ft;
        logic [15:0] row;
        logic [3:0]  num;
        logic        nw;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] G8  = 7'b0000000;
    localparam logic [6:0] GA  = 7'b0001000;
    localparam logic [6:0] G1  = 7'b1111001;
    localparam logic [6:0] GF  = 7'b0001110;

    function automatic vec_t mk(int c, logic [3:0] an, logic [6:0] seg, logic dp, logic ft,
                                logic [15:0] row, logic [3:0] num, logic nw);
        vec_t v;
        v.c = c; v.an = an; v.seg = seg; v.dp = dp; v.ft = ft;
        v.row = row; v.num = num; v.nw = nw;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] an_e, input logic [6:0] seg_e,
                         input logic dp_e, input logic ft_e);
        n_vec++;
        if (bus.an !== an_e || bus.seg !== seg_e || bus.dp !== dp_e || bus.frameTick !== ft_e) begin
            n_bad++;
            $display("FAIL %s: got an=%h seg=%b dp=%b ft=%b, expected an=%h seg=%b dp=%b ft=%b",
                     name, bus.an, bus.seg, bus.dp, bus.frameTick, an_e, seg_e, dp_e, ft_e);
        end
    endtask

    task automatic wait_cyc(input int n);
        int spins = 0;
        while (cyc < n && spins < 2000) begin
            @(negedge clk);
            spins++;
        end
        if (cyc != n) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_c%0d: reached cycle %0d, expected %0d", n, cyc, n);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        wait_cyc(v.c);
        check($sformatf("%s_c%0d", tag, v.c), v.an, v.seg, v.dp, v.ft);
        bus.currentRow = v.row;
        bus.currentNum = v.num;
        bus.noWrite    = v.nw;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        // Decode, frame tick, blink on digit 2, protected cursor on digit 0, mid-frame change.
        tbl_a.push_back(mk(  1, 4'hF, BLK, 1, 0, 16'h1A08, 4'h0, 0));
        tbl_a.push_back(mk(  3, 4'hE, BLK, 1, 0, 16'h1A08, 4'h0, 0));
        tbl_a.push_back(mk( 32, 4'h7, BLK, 1, 1, 16'h1A08, 4'h0, 0));
        tbl_a.push_back(mk( 33, 4'hF, BLK, 1, 0, 16'h1A08, 4'h0, 0));
        tbl_a.push_back(mk( 35, 4'hE, G8,  1, 0, 16'h1A08, 4'h0, 0));
        tbl_a.push_back(mk( 40, 4'hE, G8,  1, 0, 16'h1A08, 4'h4, 0));
        tbl_a.push_back(mk( 43, 4'hD, BLK, 1, 0, 16'h1A08, 4'h4, 0));
        tbl_a.push_back(mk( 51, 4'hB, GA,  1, 0, 16'h1A08, 4'h4, 0));
        tbl_a.push_back(mk( 59, 4'h7, G1,  1, 0, 16'h1A08, 4'h4, 0));
        tbl_a.push_back(mk( 64, 4'h7, G1,  1, 1, 16'h1A08, 4'h4, 0));
        tbl_a.push_back(mk( 65, 4'hF, BLK, 1, 0, 16'h1A08, 4'h4, 0));
        tbl_a.push_back(mk( 67, 4'hE, G8,  1, 0, 16'h1A08, 4'h4, 0));
        tbl_a.push_back(mk( 83, 4'hB, BLK, 1, 0, 16'h1A08, 4'h4, 0));
        tbl_a.push_back(mk(120, 4'hB, BLK, 1, 0, 16'h1A08, 4'h4, 0));
        tbl_a.push_back(mk(131, 4'hE, G8,  1, 0, 16'h1A08, 4'h4, 0));
        tbl_a.push_back(mk(147, 4'hB, GA,  1, 0, 16'h1A08, 4'h1, 1));
        tbl_a.push_back(mk(161, 4'hF, BLK, 1, 0, 16'h1A08, 4'h1, 1));
        tbl_a.push_back(mk(163, 4'hE, G8,  0, 0, 16'h1A08, 4'h1, 1));
        tbl_a.push_back(mk(171, 4'hD, BLK, 1, 0, 16'h1A08, 4'h1, 1));
        tbl_a.push_back(mk(179, 4'hB, GA,  1, 0, 16'h1A08, 4'h1, 1));
        tbl_a.push_back(mk(195, 4'hE, BLK, 0, 0, 16'h1A08, 4'h1, 1));
        tbl_a.push_back(mk(211, 4'hB, GA,  1, 0, 16'h1A08, 4'h1, 1));
        tbl_a.push_back(mk(227, 4'hE, BLK, 0, 0, 16'h1A08, 4'h1, 1));
        tbl_a.push_back(mk(234, 4'hF, BLK, 1, 0, 16'hFFFF, 4'h1, 1));
        tbl_a.push_back(mk(243, 4'hB, GA,  1, 0, 16'hFFFF, 4'h1, 1));
        tbl_a.push_back(mk(251, 4'h7, G1,  1, 0, 16'hFFFF, 4'h1, 1));
        tbl_a.push_back(mk(259, 4'hE, GF,  0, 0, 16'hFFFF, 4'h1, 1));
        tbl_a.push_back(mk(267, 4'hD, GF,  1, 0, 16'hFFFF, 4'h1, 1));
        tbl_a.push_back(mk(275, 4'hB, GF,  1, 0, 16'hFFFF, 4'h1, 1));
        tbl_a.push_back(mk(283, 4'h7, GF,  1, 0, 16'hFFFF, 4'h1, 1));

        // After a mid-scan reset: blank first frame, then FFFF with visible phase restarted.
        tbl_b.push_back(mk(  1, 4'hF, BLK, 1, 0, 16'hFFFF, 4'h1, 1));
        tbl_b.push_back(mk(  3, 4'hE, BLK, 1, 0, 16'hFFFF, 4'h1, 1));
        tbl_b.push_back(mk( 11, 4'hD, BLK, 1, 0, 16'hFFFF, 4'h1, 1));
        tbl_b.push_back(mk( 32, 4'h7, BLK, 1, 1, 16'hFFFF, 4'h1, 1));
        tbl_b.push_back(mk( 35, 4'hE, GF,  0, 0, 16'hFFFF, 4'h1, 1));
        tbl_b.push_back(mk( 43, 4'hD, GF,  1, 0, 16'hFFFF, 4'h1, 1));
        tbl_b.push_back(mk( 67, 4'hE, BLK, 0, 0, 16'hFFFF, 4'h1, 1));
        tbl_b.push_back(mk( 99, 4'hE, BLK, 0, 0, 16'hFFFF, 4'h1, 1));
        tbl_b.push_back(mk(131, 4'hE, GF,  0, 0, 16'hFFFF, 4'h1, 1));

        bus.currentRow = 16'h1A08;
        bus.currentNum = 4'h0;
        bus.noWrite    = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_hold", 4'hF, BLK, 1'b1, 1'b0);
        rst = 1'b0;

        foreach (tbl_a[i]) run(tbl_a[i], "a");

        // Reset asserted while the scan sits in slot 2 at prescaler 5.
        wait_cyc(309);
        check("pre_reset", 4'hB, GF, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset", 4'hF, BLK, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl_b[i]) run(tbl_b[i], "b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream display stage for the interface controller.
- Consumes the selected 4-digit row and the one-hot cursor, and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Blinks the cursor digit and marks write-protected cursor positions with the decimal point.
- Owns all display timing: scan prescaler, digit counter, blink divider, frame-aligned input shadowing.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot. Range GUARD+2..65535; prescaler is 16 bits.
- GUARD, 4: cycles at the start of each slot with all anodes off (anti-ghosting). Must be at least 1.
- BLINK_DIV, 64: frames per blink half-period. Must be at least 1.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- currentRow  in  16  four hex digits; nibble i = currentRow[4i+3:4i] is shown on digit i; value 0 means blank
- currentNum  in  4  cursor; bit i set means digit i is selected
- noWrite  in  1  selected location is write-protected
- seg  out  7  segments, active-low; seg[0]=a ... seg[6]=g
- dp  out  1  decimal point, active-low
- an  out  4  digit anodes, active-low; an[i] enables digit i
- frameTick  out  1  one-cycle pulse at every frame boundary

Behaviour:
- Reset (takes priority every cycle, including mid-scan):
  - an=4'hF, seg=7'h7F, dp=1, frameTick=0.
  - Prescaler=0, digit index=0, blink counter=0, blinkPhase=visible.
  - Shadow row/cursor/noWrite cleared to 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - At SCAN_DIV-1 the digit index increments, wrapping 3->0.
  - A slot is SCAN_DIV cycles; a frame is 4 slots, scanned in digit order 0,1,2,3.
- Frame boundary (prescaler=SCAN_DIV-1 and index=3):
  - currentRow, currentNum and noWrite are latched into shadow registers.
  - frameTick=1 on the following cycle only.
  - Blink counter increments; at BLINK_DIV-1 it wraps to 0 and blinkPhase toggles.
- Inputs are sampled only at frame boundaries. Changes mid-frame are invisible until the next frame; no tearing within a frame.
- All outputs are registered. Output values in the cycle after the prescaler reaches p within slot i:
  - p<GUARD: an=4'hF, seg=7'h7F, dp=1.
  - Otherwise: an = all ones except bit i low; seg = decode(shadow nibble i); dp as below.
- Decode (active-low {g,f,e,d,c,b,a}):
  - 0 gives blank 1111111.
  - 1-F use standard hex glyphs: 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Blink:
  - If shadow cursor bit i is set and blinkPhase=hidden, seg=7'h7F for digit i; the anode is still driven.
  - Each set bit blinks independently. Cursor 0 means nothing blinks. Multi-hot means all set digits blink.
- Decimal point: dp=0 on digit i when cursor bit i=1 and shadow noWrite=1, independent of blinkPhase; dp=1 otherwise.
- Blink half-period = BLINK_DIV*4*SCAN_DIV cycles.

Test Plan (SCAN_DIV=8, GUARD=2, BLINK_DIV=2):
1. Reset: hold RST 3 cycles, then release -> an=F, seg=7F, dp=1 during reset; scan begins at digit 0 with prescaler 0.
2. Decode: currentRow=16'h1A08, currentNum=0, after the first frame boundary -> slots show an=E/seg=0000000, an=D/seg=1111111, an=B/seg=0001000, an=7/seg=1111001. Each slot has an=F for its first 2 cycles; frameTick pulses every 32 cycles.
3. Blink: currentNum=4'b0100, currentRow=16'h1A08 -> digit 2 shows 0001000 for 64 cycles, then 1111111 for 64 cycles, alternating; other digits are unaffected.
4. Protected cursor: noWrite=1, currentNum=4'b0001 -> dp=0 only in digit-0 slots (outside guard), in both blink phases.
5. Mid-frame change: change currentRow from 16'h1A08 to 16'hFFFF during slot 1 -> slots 2 and 3 still show A and 1; the next frame shows F (0001110) on all digits.
6. Reset mid-scan: assert RST in slot 2 at prescaler 5 -> next cycle outputs equal reset values; after release, scan restarts at digit 0, shadows are 0 (all blank), blinkPhase=visible.
